// File: rtl/car_kinematics_pkg.sv
// Shared types and fixed-point constants for the per-player car motion engine.
package car_kinematics_pkg;

  localparam int POS_W  = 17;  // signed 10.6 fixed-point position
  localparam int FRAC   = 6;
  localparam int TRIG_W = 9;   // signed sin/cos, scaled by 128
  localparam int SPD_W  = 9;   // signed speed, 1/64 px per frame
  localparam int DEG_W  = 9;

  localparam logic [3:0] COL_WALL  = 4'd0;
  localparam logic [3:0] COL_ROAD  = 4'd1;
  localparam logic [3:0] COL_KERB  = 4'd2;
  localparam logic [3:0] COL_GRASS = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_ACCEL,
    S_CALC,
    S_REQ,
    S_WAIT,
    S_CHECK
  } state_t;

endpackage

// File: rtl/car_kinematics_if.sv
// Controls, map BRAM read port and committed-pose bundle of one car_kinematics instance.
interface car_kinematics_if;
  import car_kinematics_pkg::*;

  logic                    frame_tick;
  logic                    up;
  logic                    down;
  logic                    left;
  logic                    right;
  logic [16:0]             map_addr;
  logic                    map_rd_en;
  logic [3:0]              map_data;
  logic [9:0]              world_x;
  logic [9:0]              world_y;
  logic [DEG_W-1:0]        degree;
  logic signed [SPD_W-1:0] speed;
  logic                    busy;
  logic                    update_done;
  logic                    collided;

  modport master (
    input  frame_tick, up, down, left, right, map_data,
    output map_addr, map_rd_en, world_x, world_y, degree, speed,
           busy, update_done, collided
  );

  modport slave (
    output frame_tick, up, down, left, right, map_data,
    input  map_addr, map_rd_en, world_x, world_y, degree, speed,
           busy, update_done, collided
  );
endinterface

// File: rtl/car_kinematics_trig_lut.sv
// Combinational heading -> {sin, cos} lookup, signed 9-bit scaled by 128, 15-degree entries.
module car_trig_lut
  import car_kinematics_pkg::*;
(
  input  logic [DEG_W-1:0]         degree,
  output logic signed [TRIG_W-1:0] sin_val,
  output logic signed [TRIG_W-1:0] cos_val
);

  // First-quadrant sine table; other quadrants fold onto it.
  function automatic logic signed [TRIG_W-1:0] quarter(input logic [DEG_W-1:0] a);
    case (a)
      9'd0:    quarter = 9'sd0;
      9'd15:   quarter = 9'sd33;
      9'd30:   quarter = 9'sd64;
      9'd45:   quarter = 9'sd91;
      9'd60:   quarter = 9'sd111;
      9'd75:   quarter = 9'sd124;
      9'd90:   quarter = 9'sd128;
      default: quarter = 9'sd0;
    endcase
  endfunction

  always_comb begin
    sin_val = '0;
    cos_val = '0;
    if (degree < 9'd90) begin
      sin_val = quarter(degree);
      cos_val = quarter(9'd90 - degree);
    end else if (degree < 9'd180) begin
      sin_val = quarter(9'd180 - degree);
      cos_val = -quarter(degree - 9'd90);
    end else if (degree < 9'd270) begin
      sin_val = -quarter(degree - 9'd180);
      cos_val = -quarter(9'd270 - degree);
    end else begin
      sin_val = -quarter(9'd360 - degree);
      cos_val = quarter(degree - 9'd270);
    end
  end

endmodule

// File: rtl/car_kinematics.sv
// Per-player motion engine: per frame_tick, turn, accelerate, move and validate against the track map.
// Optional macro CAR_WALL_BOUNCE_EN: rejected moves bounce back at half speed instead of stopping.
module car_kinematics
  import car_kinematics_pkg::*;
#(
  parameter int          MAP_WIDTH     = 320,
  parameter int          MAP_HEIGHT    = 240,
  parameter int          START_X       = 15,
  parameter int          START_Y       = 125,
  parameter int          START_DEG     = 0,
  parameter int          DEG_STEP      = 15,
  parameter int          ACCEL         = 16,
  parameter int          FRICTION      = 4,
  parameter int          MAX_SPEED     = 128,
  parameter int          MAX_REV       = 64,
  parameter logic [15:0] PASSABLE_MASK = 16'h003E,
  parameter int          MAP_LATENCY   = 1
) (
  input logic             clk,
  input logic             rst,
  car_kinematics_if.master bus
);

  localparam logic signed [POS_W-1:0] X_LIM    = POS_W'(MAP_WIDTH << FRAC);
  localparam logic signed [POS_W-1:0] Y_LIM    = POS_W'(MAP_HEIGHT << FRAC);
  localparam logic signed [POS_W-1:0] START_XF = POS_W'(START_X << FRAC);
  localparam logic signed [POS_W-1:0] START_YF = POS_W'(START_Y << FRAC);
  localparam logic [DEG_W-1:0]        DEG_ST   = DEG_W'(DEG_STEP);
  localparam logic [DEG_W-1:0]        DEG_TOP  = DEG_W'(360 - DEG_STEP);
  localparam logic [DEG_W-1:0]        DEG_INIT = DEG_W'(START_DEG);
  localparam logic signed [SPD_W-1:0] ACC_S    = SPD_W'(ACCEL);
  localparam logic signed [SPD_W-1:0] FRIC_S   = SPD_W'(FRICTION);
  localparam logic signed [SPD_W-1:0] NFRIC_S  = SPD_W'(-FRICTION);
  localparam logic signed [SPD_W-1:0] MAX_S    = SPD_W'(MAX_SPEED);
  localparam logic signed [SPD_W-1:0] MIN_S    = SPD_W'(-MAX_REV);
  localparam logic [7:0]              WAIT_LAST = 8'(MAP_LATENCY - 1);

  state_t state, state_nx;

  logic                          do_turn, do_accel, do_calc, do_req, do_wait, do_check, busy_c;
  logic [7:0]                    wait_cnt;
  logic signed [POS_W-1:0]       pos_x, pos_y, cand_x, cand_y;
  logic signed [POS_W-1:0]       dx, dy, cx, cy;
  logic                          oob, oob_c, accept;
  logic [DEG_W-1:0]              deg_r, deg_n, deg_turn;
  logic signed [SPD_W-1:0]       spd_r, spd_n, spd_acc, spd_rej;
  logic signed [TRIG_W-1:0]      sin_v, cos_v;
  logic signed [SPD_W+TRIG_W-1:0] prod_x, prod_y;
  logic [16:0]                   addr_c, map_addr_r;
  logic                          rd_en_r, done_r, col_r;

  car_trig_lut u_trig (
    .degree  (deg_n),
    .sin_val (sin_v),
    .cos_val (cos_v)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.frame_tick) state_nx = S_TURN;
      S_TURN:  state_nx = S_ACCEL;
      S_ACCEL: state_nx = S_CALC;
      S_CALC:  state_nx = oob_c ? S_CHECK : S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST) state_nx = S_CHECK;
      S_CHECK: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state != S_IDLE);
    do_turn  = (state == S_TURN);
    do_accel = (state == S_ACCEL);
    do_calc  = (state == S_CALC);
    do_req   = (state == S_REQ);
    do_wait  = (state == S_WAIT);
    do_check = (state == S_CHECK);
  end

  always_comb begin
    deg_turn = deg_r;
    if (bus.left && !bus.right)
      deg_turn = (deg_r == '0) ? DEG_TOP : deg_r - DEG_ST;
    else if (bus.right && !bus.left)
      deg_turn = (deg_r >= DEG_TOP) ? deg_r - DEG_TOP : deg_r + DEG_ST;
  end

  // Speed range stays within -MAX_REV-ACCEL..MAX_SPEED+ACCEL, so 9-bit signed never overflows.
  always_comb begin
    spd_acc = '0;
    if (bus.up && !bus.down)
      spd_acc = (spd_r + ACC_S > MAX_S) ? MAX_S : spd_r + ACC_S;
    else if (bus.down && !bus.up)
      spd_acc = (spd_r - ACC_S < MIN_S) ? MIN_S : spd_r - ACC_S;
    else if (spd_r > FRIC_S)
      spd_acc = spd_r - FRIC_S;
    else if (spd_r < NFRIC_S)
      spd_acc = spd_r + FRIC_S;
  end

  always_comb begin
    prod_x = spd_n * sin_v;
    prod_y = spd_n * cos_v;
    dx     = POS_W'(prod_x >>> 7);
    dy     = -POS_W'(prod_y >>> 7);
    cx     = pos_x + dx;
    cy     = pos_y + dy;
    oob_c  = (cx < 0) || (cx >= X_LIM) || (cy < 0) || (cy >= Y_LIM);
    addr_c = 17'(cand_y[POS_W-2:FRAC]) * 17'(MAP_WIDTH) + 17'(cand_x[POS_W-2:FRAC]);
    accept = !oob && PASSABLE_MASK[bus.map_data];
`ifdef CAR_WALL_BOUNCE_EN
    spd_rej = -(spd_n >>> 1);
`else
    spd_rej = '0;
`endif
  end

  // Heading/speed live in deg_n/spd_n until CHECK so outputs only move with update_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x      <= START_XF;
      pos_y      <= START_YF;
      deg_r      <= DEG_INIT;
      deg_n      <= DEG_INIT;
      spd_r      <= '0;
      spd_n      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      oob        <= 1'b0;
      wait_cnt   <= '0;
      map_addr_r <= '0;
      rd_en_r    <= 1'b0;
      done_r     <= 1'b0;
      col_r      <= 1'b0;
    end else begin
      rd_en_r  <= do_req;
      done_r   <= do_check;
      wait_cnt <= do_wait ? wait_cnt + 8'd1 : '0;
      if (do_turn)  deg_n <= deg_turn;
      if (do_accel) spd_n <= spd_acc;
      if (do_calc) begin
        cand_x <= cx;
        cand_y <= cy;
        oob    <= oob_c;
      end
      if (do_req) map_addr_r <= addr_c;
      if (do_check) begin
        deg_r <= deg_n;
        if (accept) begin
          pos_x <= cand_x;
          pos_y <= cand_y;
          spd_r <= spd_n;
          col_r <= 1'b0;
        end else begin
          spd_r <= spd_rej;
          col_r <= 1'b1;
        end
      end
    end
  end

  assign bus.map_addr    = map_addr_r;
  assign bus.map_rd_en   = rd_en_r;
  assign bus.world_x     = pos_x[POS_W-2:FRAC];
  assign bus.world_y     = pos_y[POS_W-2:FRAC];
  assign bus.degree      = deg_r;
  assign bus.speed       = spd_r;
  assign bus.busy        = busy_c;
  assign bus.update_done = done_r;
  assign bus.collided    = col_r;

endmodule
